// File: rtl/mc_controller.sv
// Main control FSM for the multicycle MIPS datapath, with ready-handshaked memory and a wait watchdog.
// Optional build macro MC_ILLEGAL_TRAP_EN: unknown opcodes lock the FSM in TRAP until reset.
module mc_controller #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       memtoreg,
    output logic       regdst,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       pcen,
    output logic       timeout,
    output logic [3:0] state
);

    localparam int unsigned CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ANDIEX  = 4'd12,
        ANDIWB  = 4'd13,
        BNEEX   = 4'd14,
        TRAP    = 4'd15
    } state_t;

    state_t state_q, state_d;
    logic   pcwrite;
    logic   waiting;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    assign state = state_q;

    // Cycles spent stalled on a memory handshake
    assign waiting = reset && !memready &&
                     (state_q == FETCH || state_q == MEMRD || state_q == MEMWR);

    // Next state and Moore decode; memory-gated enables and pcen depend on inputs
    always_comb begin
        state_d  = state_q;
        memread  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        pcwrite  = 1'b0;
        pcen     = 1'b0;

        case (state_q)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
                if (memready) state_d = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_BNE:       state_d = BNEEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ANDI:      state_d = ANDIEX;
                    OP_J:         state_d = JEX;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (memready) state_d = MEMWB;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (memready) state_d = FETCH;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            BEQEX, BNEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ANDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                state_d = ANDIWB;
            end
            ADDIWB, ANDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                state_d = FETCH;
            end
`ifdef MC_ILLEGAL_TRAP_EN
            default: state_d = TRAP;
`else
            default: state_d = FETCH;
`endif
        endcase

        pcen = pcwrite | ((state_q == BEQEX) & zero) | ((state_q == BNEEX) & ~zero);

        // Asserted reset forces every enable low, even mid-instruction
        if (!reset) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
            iord     = 1'b0;
            memtoreg = 1'b0;
            regdst   = 1'b0;
            alusrca  = 1'b0;
            alusrcb  = 2'b00;
            pcsrc    = 2'b00;
            aluop    = 2'b00;
            pcen     = 1'b0;
        end
    end

    generate
        if (WAIT_LIMIT > 0) begin : g_wait
            logic [CNT_W-1:0] wait_cnt;
            logic             hit;

            // Pulse on the WAIT_LIMIT-th consecutive stalled cycle, then restart the count
            assign hit     = waiting && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));
            assign timeout = hit;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset)                wait_cnt <= '0;
                else if (!waiting || hit)  wait_cnt <= '0;
                else                       wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end else begin : g_nowait
            logic unused_waiting;
            assign unused_waiting = waiting;
            assign timeout        = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller, built with WAIT_LIMIT = 4.
module tb_mc_controller;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       memready;
    logic       memread, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic       pcen, timeout;
    logic [3:0] state;
    logic [15:0] outs;

    int checks = 0;
    int passed = 0;

    mc_controller #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .pcen(pcen),
        .timeout(timeout), .state(state)
    );

    assign outs = {memread, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                   alusrcb, pcsrc, aluop, pcen, timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; op = 6'd0; zero = 1'b0; memready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (state !== 4'd0) $display("FAIL reset_state: got %0d exp 0", state); else passed++;
        checks++; if (outs !== 16'h0) $display("FAIL reset_outs: got %h exp 0000", outs); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (irwrite !== 1'b1) $display("FAIL fetch_irwrite: got %b exp 1", irwrite); else passed++;
        checks++; if (pcen !== 1'b1) $display("FAIL fetch_pcen: got %b exp 1", pcen); else passed++;
        checks++; if (alusrcb !== 2'b01 || memread !== 1'b1)
            $display("FAIL fetch_decode: got alusrcb=%b memread=%b exp 01/1", alusrcb, memread); else passed++;
        memready = 1'b0;
        #1;
        checks++; if (irwrite !== 1'b0 || pcen !== 1'b0)
            $display("FAIL fetch_stall: got irwrite=%b pcen=%b exp 0/0", irwrite, pcen); else passed++;
        next_cycle();
        checks++; if (state !== 4'd0) $display("FAIL fetch_hold: got %0d exp 0", state); else passed++;
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
        logic       mr     [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        op = 6'b100011;
        for (int i = 0; i < 9; i++) begin
            memready = mr[i];
            #1;
            checks++; if (state !== exp_st[i])
                $display("FAIL lw_state[%0d]: got %0d exp %0d", i, state, exp_st[i]); else passed++;
            checks++; if (regwrite !== (exp_st[i] == 4'd4) || memtoreg !== (exp_st[i] == 4'd4))
                $display("FAIL lw_wb[%0d]: got regwrite=%b memtoreg=%b", i, regwrite, memtoreg); else passed++;
            if (exp_st[i] == 4'd3) begin
                checks++; if (memread !== 1'b1 || iord !== 1'b1)
                    $display("FAIL lw_memrd[%0d]: got memread=%b iord=%b exp 1/1", i, memread, iord); else passed++;
            end
            if (i < 8) next_cycle();
        end
    endtask

    task automatic test_branch();
        op = 6'b000100; zero = 1'b1; memready = 1'b1;
        #1;
        next_cycle();
        checks++; if (state !== 4'd1 || alusrcb !== 2'b11)
            $display("FAIL beq_decode: got state=%0d alusrcb=%b exp 1/11", state, alusrcb); else passed++;
        next_cycle();
        checks++; if (state !== 4'd8) $display("FAIL beq_state: got %0d exp 8", state); else passed++;
        checks++; if (pcen !== 1'b1) $display("FAIL beq_pcen: got %b exp 1", pcen); else passed++;
        checks++; if (aluop !== 2'b01 || pcsrc !== 2'b01 || alusrca !== 1'b1)
            $display("FAIL beq_ctrl: got aluop=%b pcsrc=%b alusrca=%b", aluop, pcsrc, alusrca); else passed++;
        next_cycle();
        op = 6'b000101;
        #1;
        checks++; if (state !== 4'd0) $display("FAIL beq_return: got %0d exp 0", state); else passed++;
        next_cycle();
        next_cycle();
        checks++; if (state !== 4'd14) $display("FAIL bne_state: got %0d exp 14", state); else passed++;
        checks++; if (pcen !== 1'b0) $display("FAIL bne_pcen_zero1: got %b exp 0", pcen); else passed++;
        checks++; if (aluop !== 2'b01 || pcsrc !== 2'b01)
            $display("FAIL bne_ctrl: got aluop=%b pcsrc=%b exp 01/01", aluop, pcsrc); else passed++;
        zero = 1'b0;
        #1;
        checks++; if (pcen !== 1'b1) $display("FAIL bne_pcen_zero0: got %b exp 1", pcen); else passed++;
        next_cycle();
    endtask

    task automatic test_andi();
        op = 6'b001100; zero = 1'b0; memready = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        checks++; if (state !== 4'd12) $display("FAIL andi_ex_state: got %0d exp 12", state); else passed++;
        checks++; if (aluop !== 2'b11 || alusrcb !== 2'b10 || regwrite !== 1'b0)
            $display("FAIL andi_ex_ctrl: got aluop=%b alusrcb=%b regwrite=%b", aluop, alusrcb, regwrite); else passed++;
        next_cycle();
        checks++; if (state !== 4'd13) $display("FAIL andi_wb_state: got %0d exp 13", state); else passed++;
        checks++; if (regwrite !== 1'b1 || regdst !== 1'b0)
            $display("FAIL andi_wb_ctrl: got regwrite=%b regdst=%b exp 1/0", regwrite, regdst); else passed++;
        next_cycle();
        checks++; if (state !== 4'd0) $display("FAIL andi_return: got %0d exp 0", state); else passed++;
    endtask

    task automatic test_jump();
        op = 6'b000010; memready = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        checks++; if (state !== 4'd11 || pcsrc !== 2'b10 || pcen !== 1'b1)
            $display("FAIL jump: got state=%0d pcsrc=%b pcen=%b exp 11/10/1", state, pcsrc, pcen); else passed++;
        next_cycle();
    endtask

    task automatic test_timeout();
        memready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            #1;
            checks++; if (timeout !== (i == 4 || i == 8))
                $display("FAIL timeout[%0d]: got %b exp %b", i, timeout, (i == 4 || i == 8)); else passed++;
            checks++; if (irwrite !== 1'b0 || state !== 4'd0)
                $display("FAIL timeout_hold[%0d]: got irwrite=%b state=%0d", i, irwrite, state); else passed++;
            next_cycle();
        end
    endtask

    task automatic test_sw_reset();
        op = 6'b101011; memready = 1'b1;
        #1;
        next_cycle();
        memready = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (state !== 4'd5 || memwrite !== 1'b1 || iord !== 1'b1)
            $display("FAIL sw_memwr: got state=%0d memwrite=%b iord=%b", state, memwrite, iord); else passed++;
        reset = 1'b0;
        #1;
        checks++; if (memwrite !== 1'b0 || state !== 4'd0 || outs !== 16'h0)
            $display("FAIL sw_abort: got memwrite=%b state=%0d outs=%h", memwrite, state, outs); else passed++;
        next_cycle();
        reset = 1'b1;
        #1;
        checks++; if (state !== 4'd0) $display("FAIL sw_after_reset: got %0d exp 0", state); else passed++;
    endtask

    task automatic test_illegal();
        op = 6'b111111; memready = 1'b1;
        #1;
        next_cycle();
        checks++; if (state !== 4'd1) $display("FAIL illegal_decode: got %0d exp 1", state); else passed++;
        next_cycle();
`ifdef MC_ILLEGAL_TRAP_EN
        checks++; if (state !== 4'd15 || outs !== 16'h0)
            $display("FAIL illegal_trap: got state=%0d outs=%h exp 15/0000", state, outs); else passed++;
        next_cycle();
        checks++; if (state !== 4'd15) $display("FAIL illegal_trap_hold: got %0d exp 15", state); else passed++;
`else
        checks++; if (state !== 4'd0 || irwrite !== 1'b1)
            $display("FAIL illegal_return: got state=%0d irwrite=%b exp 0/1", state, irwrite); else passed++;
        next_cycle();
        checks++; if (state !== 4'd1) $display("FAIL illegal_refetch: got %0d exp 1", state); else passed++;
`endif
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_branch();
        test_andi();
        test_jump();
        test_timeout();
        test_sw_reset();
        test_illegal();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. Per state it drives the datapath mux selects, register, IR and memory enables, and the 2-bit aluop consumed by the ALU decoder. Memory accesses use a ready handshake, so fetch, load and store stall on slow memory.

Parameters:
WAIT_LIMIT, 15, consecutive memory-wait cycles before a timeout pulse; 0 disables the wait counter.

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
op  input  6  instruction opcode, IR[31:26]
zero  input  1  ALU zero flag
memready  input  1  memory has completed the current read or write this cycle
memread  output  1  memory read request
memwrite  output  1  memory write request
irwrite  output  1  load instruction register
regwrite  output  1  register file write enable
iord  output  1  address mux: 0 = PC, 1 = ALUOut
memtoreg  output  1  writeback data: 0 = ALUOut, 1 = Data
regdst  output  1  destination: 0 = rt, 1 = rd
alusrca  output  1  ALU A: 0 = PC, 1 = A register
alusrcb  output  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
pcsrc  output  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
aluop  output  2  00 = add, 01 = sub, 10 = funct decode, 11 = and
pcen  output  1  PC write enable
timeout  output  1  one-cycle pulse on memory-wait limit
state  output  4  current state, for debug

Behaviour:
- reset low: state = FETCH (0), wait counter = 0, every output = 0 including the state-dependent ones. The FSM runs from the first clock edge after reset rises. Reset mid-instruction aborts it with no further enables.
- Outputs are Moore-decoded from state, with two exceptions: pcen and the memory-gated enables. Every output not listed for a state is 0.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, ANDIEX 12, ANDIWB 13, BNEEX 14, TRAP 15.
- FETCH: memread = 1, alusrcb = 01.
  - irwrite = memready, and pcwrite = memready.
  - Holds in FETCH while memready = 0; goes to DECODE when memready = 1.
- DECODE: alusrcb = 11. Next state by op:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> RTYPEEX
  - 000100 (beq) -> BEQEX
  - 000101 (bne) -> BNEEX
  - 001000 (addi) -> ADDIEX
  - 001100 (andi) -> ANDIEX
  - 000010 (j) -> JEX
  - any other op -> see Optional Feature
- MEMADR: alusrca = 1, alusrcb = 10. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: iord = 1, memread = 1. Holds until memready = 1, then goes to MEMWB.
- MEMWB: regwrite = 1, memtoreg = 1, then FETCH.
- MEMWR: iord = 1, memwrite = 1. memwrite stays high until the memready cycle, then FETCH.
- RTYPEEX: alusrca = 1, aluop = 10, then RTYPEWB.
- RTYPEWB: regdst = 1, regwrite = 1, then FETCH.
- BEQEX and BNEEX: alusrca = 1, aluop = 01, pcsrc = 01, then FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, then ADDIWB.
- ANDIEX: alusrca = 1, alusrcb = 10, aluop = 11, then ANDIWB.
- ADDIWB and ANDIWB: regwrite = 1, then FETCH.
- JEX: pcsrc = 10, pcwrite = 1, then FETCH.
- pcen = pcwrite | (BEQEX & zero) | (BNEEX & ~zero), evaluated combinationally.
- Wait counter, width $clog2(WAIT_LIMIT+1):
  - Increments each cycle the FSM is in FETCH, MEMRD or MEMWR with memready = 0.
  - Clears on memready = 1 or on any other state.
  - On reaching WAIT_LIMIT: timeout = 1 for one cycle and the counter clears. The FSM keeps waiting; the timeout is non-fatal.
- memready outside FETCH, MEMRD and MEMWR is ignored.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP. TRAP holds all outputs 0 except state = 15 until reset.
- Undefined: an unknown op in DECODE returns to FETCH with no side effects. State 15 is unreachable.

Test Plan:
- reset low, clk toggling -> state = 0 and all outputs 0; after release with memready = 1 -> irwrite = pcen = 1 in the first FETCH cycle.
- lw (op = 100011), memready = 1 in FETCH and low for 3 cycles in MEMRD -> states 0, 1, 2, 3, 3, 3, 3, 4, 0; regwrite = memtoreg = 1 only in state 4.
- beq with zero = 1, then bne with zero = 1 -> pcen = 1 in BEQEX only; both have aluop = 01 and pcsrc = 01.
- andi (op = 001100) -> ANDIEX with aluop = 11 and alusrcb = 10, then ANDIWB regwrite = 1, regdst = 0.
- WAIT_LIMIT = 4, memready held 0 in FETCH -> timeout pulses at cycles 4 and 8 of the wait; irwrite stays 0 throughout.
- op = 111111 -> with MC_ILLEGAL_TRAP_EN, state goes to 15 and stays there; without it, state returns to 0. Reset low mid-MEMWR drops memwrite immediately.
